// File: rtl/basys_mmio_display_pkg.sv
// Shared constants and types for the Basys memory-mapped display peripheral.
package basys_io_pkg;

  localparam logic [31:0] DISP_ADDR_DEF = 32'h0000_00C0;
  localparam logic [31:0] LED_ADDR_DEF  = 32'h0000_00C4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef logic [1:0] digit_t;

  // Active-low one-hot anode select for a digit slot
  function automatic logic [3:0] an_select(input digit_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/basys_mmio_display_if.sv
// Store-bus snoop interface between the core top level and the display peripheral.
interface basys_mmio_display_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  modport master (output MemWrite, output DataAdr, output WriteData);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/basys_mmio_display_hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import basys_io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/basys_mmio_display.sv
// Snoops core stores to drive the Basys 4-digit seven-segment display and LEDs.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module basys_mmio_display
  import basys_io_pkg::*;
#(
  parameter logic [31:0] DISP_ADDR   = DISP_ADDR_DEF,
  parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  basys_mmio_display_if.slave        bus,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [3:0]                 an,
  output logic [15:0]                led
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [15:0]      disp_q, disp_d;
  logic [15:0]      led_q,  led_d;
  logic [PRE_W-1:0] pre_q,  pre_d;
  digit_t           digit_q, digit_d;
  logic [3:0]       an_q,   an_d;
  logic [6:0]       seg_q,  seg_d;

  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic       blank;

  // Only the low half-word of a store is meaningful to this peripheral
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^bus.WriteData[31:16];

  assign nibble = disp_q[{digit_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  digit_t msd;

  // Digit 0 is never blanked, so an all-zero value still shows a single 0
  always_comb begin
    msd = 2'd0;
    if (disp_q[15:12] != 4'h0)     msd = 2'd3;
    else if (disp_q[11:8] != 4'h0) msd = 2'd2;
    else if (disp_q[7:4] != 4'h0)  msd = 2'd1;
    blank = (digit_q > msd);
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  always_comb begin
    disp_d  = disp_q;
    led_d   = led_q;
    pre_d   = pre_q;
    digit_d = digit_q;

    if (bus.MemWrite && (bus.DataAdr == DISP_ADDR)) disp_d = bus.WriteData[15:0];
    if (bus.MemWrite && (bus.DataAdr == LED_ADDR))  led_d  = bus.WriteData[15:0];

    if (pre_q == PRE_LAST) begin
      pre_d   = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      pre_d   = pre_q + 1'b1;
    end

    // Output stage samples the current digit/data, hence the one-cycle lag
    an_d  = blank ? AN_OFF    : an_select(digit_q);
    seg_d = blank ? SEG_BLANK : seg_dec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q  <= '0;
      led_q   <= '0;
      pre_q   <= '0;
      digit_q <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      disp_q  <= disp_d;
      led_q   <= led_d;
      pre_q   <= pre_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign led = led_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_basys_mmio_display.sv
// Scoreboard bench for basys_mmio_display with a 4-cycle digit slot.
module tb_basys_mmio_display;

  localparam int unsigned DIV = 4;

  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] led;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] led;

  basys_mmio_display_if bus ();

  basys_mmio_display #(
    .DISP_ADDR   (32'h0000_00C0),
    .LED_ADDR    (32'h0000_00C4),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data, input logic we);
    bus.MemWrite  = we;
    bus.DataAdr   = adr;
    bus.WriteData = data;
    tick();
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;
  endtask

  task automatic push_slot(input logic [3:0] a, input logic [6:0] s, input logic [15:0] l);
    exp_t e;
    e.an  = a;
    e.seg = s;
    e.led = l;
    for (int i = 0; i < DIV; i++) sb_q.push_back(e);
  endtask

  // Compare the current sample against each queued cycle, advancing one clock per entry
  task automatic drain(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_an"},  {28'h0, an},  {28'h0, e.an});
      chk({tag, "_seg"}, {25'h0, seg}, {25'h0, e.seg});
      chk({tag, "_led"}, {16'h0, led}, {16'h0, e.led});
      tick();
    end
  endtask

  // Align to the first sample of a digit-0 slot; bounded so a dead scan cannot hang the run
  task automatic sync_slot0(input string tag);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 * DIV && !found; i++) begin
      prev = an;
      tick();
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    if (!found) chk({tag, "_sync_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic full_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input logic [15:0] l);
    sync_slot0(tag);
    push_slot(4'b1110, s0, l);
    push_slot(4'b1101, s1, l);
    push_slot(4'b1011, s2, l);
    push_slot(4'b0111, s3, l);
    drain(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;

    // Reset held three cycles
    tick(); tick(); tick();
    chk("rst_an",  {28'h0, an},  32'hF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_dp",  {31'h0, dp},  32'h1);

    // Release: the drop edge counts first, the next edge shows digit 0
    reset = 1'b0;
    tick();
    push_slot(4'b1110, 7'h40, 16'h0);
    push_slot(4'b1101, 7'h40, 16'h0);
    drain("post_rst");

    // Four-digit scan of 0x1234
    store(32'h0000_00C0, 32'h0000_1234, 1'b1);
    tick(); tick();
    full_scan("scan1234", 7'h19, 7'h30, 7'h24, 7'h79, 16'h0);

    // LED store, upper data ignored, display untouched
    chk("led_before", {16'h0, led}, 32'h0);
    store(32'h0000_00C4, 32'hABCD_5A5A, 1'b1);
    chk("led_after", {16'h0, led}, 32'h5A5A);
    store(32'h0000_00C4, 32'h0000_1111, 1'b0);
    tick();
    chk("led_we0", {16'h0, led}, 32'h5A5A);
    full_scan("disp_keep", 7'h19, 7'h30, 7'h24, 7'h79, 16'h5A5A);

    // Non-matching addresses (full 32-bit compare)
    store(32'h0000_01C0, 32'h0000_FFFF, 1'b1);
    store(32'h8000_00C0, 32'h0000_FFFF, 1'b1);
    store(32'h0000_00C8, 32'h0000_FFFF, 1'b1);
    store(32'h0000_00C0, 32'h0000_FFFF, 1'b0);
    chk("alias_led", {16'h0, led}, 32'h5A5A);
    full_scan("alias", 7'h19, 7'h30, 7'h24, 7'h79, 16'h5A5A);

    // Back-to-back stores: last one wins
    store(32'h0000_00C0, 32'h0000_1111, 1'b1);
    store(32'h0000_00C0, 32'h0000_2222, 1'b1);
    tick();
    full_scan("b2b", 7'h24, 7'h24, 7'h24, 7'h24, 16'h5A5A);

`ifdef LEADING_ZERO_BLANK_EN
    store(32'h0000_00C0, 32'h0000_0042, 1'b1);
    tick(); tick();
    sync_slot0("lzb42");
    push_slot(4'b1110, 7'h24, 16'h5A5A);
    push_slot(4'b1101, 7'h19, 16'h5A5A);
    push_slot(4'hF,    7'h7F, 16'h5A5A);
    push_slot(4'hF,    7'h7F, 16'h5A5A);
    drain("lzb42");

    store(32'h0000_00C0, 32'h0000_0402, 1'b1);
    tick(); tick();
    sync_slot0("lzb402");
    push_slot(4'b1110, 7'h24, 16'h5A5A);
    push_slot(4'b1101, 7'h40, 16'h5A5A);
    push_slot(4'b1011, 7'h19, 16'h5A5A);
    push_slot(4'hF,    7'h7F, 16'h5A5A);
    drain("lzb402");

    store(32'h0000_00C0, 32'h0000_0000, 1'b1);
    tick(); tick();
    sync_slot0("lzb0");
    push_slot(4'b1110, 7'h40, 16'h5A5A);
    push_slot(4'hF,    7'h7F, 16'h5A5A);
    push_slot(4'hF,    7'h7F, 16'h5A5A);
    push_slot(4'hF,    7'h7F, 16'h5A5A);
    drain("lzb0");
`else
    store(32'h0000_00C0, 32'h0000_0042, 1'b1);
    tick(); tick();
    full_scan("lead42", 7'h24, 7'h19, 7'h40, 7'h40, 16'h5A5A);
    store(32'h0000_00C0, 32'h0000_0000, 1'b1);
    tick(); tick();
    full_scan("lead0", 7'h40, 7'h40, 7'h40, 7'h40, 16'h5A5A);
`endif

    // Reset during the digit-2 slot
    store(32'h0000_00C0, 32'h0000_FFFF, 1'b1);
    tick(); tick();
    sync_slot0("midrst");
    for (int i = 0; i < 2 * DIV; i++) tick();
    chk("midrst_pre_an",  {28'h0, an},  32'hB);
    chk("midrst_pre_seg", {25'h0, seg}, 32'h0E);
    reset = 1'b1;
    tick();
    chk("midrst_an",  {28'h0, an},  32'hF);
    chk("midrst_seg", {25'h0, seg}, 32'h7F);
    chk("midrst_led", {16'h0, led}, 32'h0);
    chk("midrst_dp",  {31'h0, dp},  32'h1);
    reset = 1'b0;
    tick();
    push_slot(4'b1110, 7'h40, 16'h0);
    push_slot(4'b1101, 7'h40, 16'h0);
    drain("midrst_scan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
